// File: rtl/qmax_ctrl_if.sv
// rtl/qmax_ctrl_if.sv - request, response and BRAM port bundle of the qmax controller
interface qmax_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  clear;
  logic                  busy;

  logic                  upd_valid;
  logic                  upd_ready;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [DATA_WIDTH-1:0] upd_q;
  logic                  upd_done;
  logic                  upd_wrote;

  logic                  lk_valid;
  logic                  lk_ready;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic                  lk_rvalid;
  logic [DATA_WIDTH-1:0] lk_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // slave is the controller; master is the pipeline plus the BRAM
  modport slave (
    input  clear, upd_valid, upd_addr, upd_q, lk_valid, lk_addr, mem_rdata,
    output busy, upd_ready, upd_done, upd_wrote, lk_ready, lk_rvalid, lk_rdata,
    output mem_addr_r, mem_addr_w, mem_we, mem_wdata
  );

  modport master (
    output clear, upd_valid, upd_addr, upd_q, lk_valid, lk_addr, mem_rdata,
    input  busy, upd_ready, upd_done, upd_wrote, lk_ready, lk_rvalid, lk_rdata,
    input  mem_addr_r, mem_addr_w, mem_we, mem_wdata
  );
endinterface

// File: rtl/qmax_ctrl.sv
// rtl/qmax_ctrl.sv - qmax BRAM owner: zero-fill, running-max updates, lookup arbitration
module qmax_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  qmax_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_CMP   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic                  clr_pend;
  logic                  clr_pend_nxt;

  logic [ADDR_WIDTH-1:0] addr_r_q;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_q;
  logic                  rr_upd;
  logic                  lk_rvalid_q;
  logic                  done_q;
  logic                  wrote_q;

  logic                  gnt_upd;
  logic                  gnt_lk;
  logic                  q_gt;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_pend <= clr_pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_pend_nxt = clr_pend;
    gnt_upd      = 1'b0;
    gnt_lk       = 1'b0;
    we           = 1'b0;
    addr_w       = lat_addr;
    wdata        = lat_q;
    q_gt         = lat_q > bus.mem_rdata;

    case (state)
      S_CLEAR: begin
        // write enable is held off while reset is asserted
        we      = rst_n;
        addr_w  = cnt;
        wdata   = '0;
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_ADDR) begin
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clr_pend) begin
          state_nxt    = S_CLEAR;
          cnt_nxt      = '0;
          clr_pend_nxt = 1'b0;
        end else begin
          if (bus.clear) begin
            clr_pend_nxt = 1'b1;
          end
          gnt_upd = bus.upd_valid && (!bus.lk_valid || rr_upd);
          gnt_lk  = bus.lk_valid && (!bus.upd_valid || !rr_upd);
          if (gnt_upd) begin
            state_nxt = S_CMP;
          end
        end
      end
      S_CMP: begin
        we = q_gt;
        if (bus.clear) begin
          clr_pend_nxt = 1'b1;
        end
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r_q    <= '0;
      lat_addr    <= '0;
      lat_q       <= '0;
      rr_upd      <= 1'b1;
      lk_rvalid_q <= 1'b0;
      done_q      <= 1'b0;
      wrote_q     <= 1'b0;
    end else begin
      addr_r_q    <= bus.mem_addr_r;
      lk_rvalid_q <= gnt_lk;
      done_q      <= (state == S_CMP);
      wrote_q     <= (state == S_CMP) && q_gt;
      if (gnt_upd) begin
        lat_addr <= bus.upd_addr;
        lat_q    <= bus.upd_q;
      end
      // the pointer always moves to whoever was not just served
      if (gnt_upd || gnt_lk) begin
        rr_upd <= gnt_lk;
      end
    end
  end

  assign bus.busy       = (state == S_CLEAR) || clr_pend;
  assign bus.upd_ready  = gnt_upd;
  assign bus.lk_ready   = gnt_lk;
  assign bus.upd_done   = done_q;
  assign bus.upd_wrote  = wrote_q;
  assign bus.lk_rvalid  = lk_rvalid_q;
  assign bus.lk_rdata   = bus.mem_rdata;
  assign bus.mem_addr_r = gnt_upd ? bus.upd_addr : (gnt_lk ? bus.lk_addr : addr_r_q);
  assign bus.mem_addr_w = addr_w;
  assign bus.mem_we     = we;
  assign bus.mem_wdata  = wdata;

endmodule

// File: tb/tb_qmax_ctrl.sv
// tb/tb_qmax_ctrl.sv - self-checking bench for qmax_ctrl against a table-level model
module tb_qmax_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   scramble = 1'b1;
  logic [DW-1:0] mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the table contents plus the externally visible schedule
  int ref_tbl [DEPTH];
  int m_clear_left;
  bit m_pend;
  bit m_cmp;
  bit m_rr_upd;
  bit m_lk_due;
  int m_lk_exp;
  int m_done_cnt;
  bit m_wrote_exp;
  int m_wr_addr;
  int m_wr_q;

  bit last_ur;
  bit last_lr;
  int last_lk;
  bit last_wrote;
  int lk_or;
  int lk_cnt;

  qmax_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  qmax_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // BRAM: one write port, one registered read port
  always @(posedge clk) begin
    if (scramble) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= DW'($urandom);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr_w] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr_r];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clear_left = DEPTH;
    m_pend       = 1'b0;
    m_cmp        = 1'b0;
    m_rr_upd     = 1'b1;
    m_lk_due     = 1'b0;
    m_done_cnt   = 0;
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 0;
  endtask

  // one clock: drive at the negedge, check, advance the model, wait for next negedge
  task automatic cycle(input bit uv, input int ua, input int uq,
                       input bit lv, input int la, input bit clr);
    bit clearing, can_grant, eg_u, eg_l, nxt_cmp;
    bus.upd_valid = uv;
    bus.upd_addr  = AW'(ua);
    bus.upd_q     = DW'(uq);
    bus.lk_valid  = lv;
    bus.lk_addr   = AW'(la);
    bus.clear     = clr;
    #1;
    clearing  = (m_clear_left > 0);
    can_grant = !clearing && !m_cmp && !m_pend;
    eg_u = can_grant && uv && (!lv || m_rr_upd);
    eg_l = can_grant && lv && (!uv || !m_rr_upd);

    chk("busy", bus.busy, clearing || m_pend);
    chk("upd_ready", bus.upd_ready, eg_u);
    chk("lk_ready", bus.lk_ready, eg_l);
    last_ur = bus.upd_ready;
    last_lr = bus.lk_ready;
    chk("lk_rvalid", bus.lk_rvalid, m_lk_due);
    if (m_lk_due) begin
      chk("lk_rdata", bus.lk_rdata, m_lk_exp);
      last_lk = bus.lk_rdata;
      lk_or  |= int'(bus.lk_rdata);
      lk_cnt++;
    end
    chk("upd_done", bus.upd_done, m_done_cnt == 1);
    if (m_done_cnt == 1) begin
      chk("upd_wrote", bus.upd_wrote, m_wrote_exp);
      last_wrote = bus.upd_wrote;
    end
    if (clearing) begin
      chk("clr_we", bus.mem_we, 1'b1);
      chk("clr_addr", bus.mem_addr_w, DEPTH - m_clear_left);
      chk("clr_wdata", bus.mem_wdata, 0);
    end else if (m_cmp) begin
      chk("cmp_we", bus.mem_we, m_wrote_exp);
      if (m_wrote_exp) begin
        chk("cmp_addr", bus.mem_addr_w, m_wr_addr);
        chk("cmp_wdata", bus.mem_wdata, m_wr_q);
      end
    end else begin
      chk("idle_we", bus.mem_we, 1'b0);
    end

    m_lk_due = eg_l;
    if (eg_l) m_lk_exp = ref_tbl[la];
    m_done_cnt = (m_done_cnt > 0) ? m_done_cnt - 1 : 0;
    if (eg_u) begin
      m_wrote_exp = uq > ref_tbl[ua];
      m_wr_addr   = ua;
      m_wr_q      = uq;
      if (m_wrote_exp) ref_tbl[ua] = uq;
      m_done_cnt  = 2;
    end
    if (eg_u || eg_l) m_rr_upd = eg_l;
    nxt_cmp = eg_u;
    if (clearing) begin
      m_clear_left--;
    end else if (m_pend && !m_cmp) begin
      m_clear_left = DEPTH;
      m_pend       = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 0;
    end else if (clr) begin
      m_pend = 1'b1;
    end
    m_cmp = nxt_cmp;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  // asserts reset mid-cycle, checks the reset outputs, releases on the next negedge
  task automatic reset_dut(input bit scr);
    bus.upd_valid = 1'b1;
    bus.lk_valid  = 1'b1;
    bus.clear     = 1'b0;
    #1;
    rst_n    = 1'b0;
    scramble = scr;
    #1;
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_upd_ready", bus.upd_ready, 1'b0);
    chk("rst_lk_ready", bus.lk_ready, 1'b0);
    chk("rst_lk_rvalid", bus.lk_rvalid, 1'b0);
    chk("rst_upd_done", bus.upd_done, 1'b0);
    chk("rst_upd_wrote", bus.upd_wrote, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    @(negedge clk);
    scramble = 1'b0;
    rst_n    = 1'b1;
    model_reset();
  endtask

  task automatic run_fill(input string tag, input int exp_cycles);
    int n = 0;
    while (bus.busy && n < 1000) begin
      cycle(1'b1, $urandom_range(0, DEPTH-1), $urandom_range(0, 255),
            1'b1, $urandom_range(0, DEPTH-1), 1'b0);
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask

  task automatic do_upd(input int a, input int q);
    cycle(1'b1, a, q, 1'b0, 0, 1'b0);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic do_lk(input int a);
    cycle(1'b0, 0, 0, 1'b1, a, 1'b0);
    idle_cycle();
  endtask

  task automatic sweep_zero(input string tag);
    lk_or  = 0;
    lk_cnt = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 0, 1'b1, i, 1'b0);
    idle_cycle();
    chk({tag, "_count"}, lk_cnt, DEPTH);
    chk({tag, "_or"}, lk_or, 0);
  endtask

  initial begin
    bit [7:0] pat_u, pat_l;
    int n;
    bus.clear     = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_addr  = '0;
    bus.upd_q     = '0;
    bus.lk_valid  = 1'b0;
    bus.lk_addr   = '0;

    reset_dut(1'b1);
    run_fill("fill_after_reset", DEPTH);
    do_lk(17);
    chk("lk17_zero", last_lk, 0);

    do_upd(5, 40);
    chk("upd5_40_wrote", last_wrote, 1'b1);
    do_upd(5, 30);
    chk("upd5_30_wrote", last_wrote, 1'b0);
    do_upd(5, 40);
    chk("upd5_40eq_wrote", last_wrote, 1'b0);
    do_lk(5);
    chk("lk5_max", last_lk, 40);

    cycle(1'b1, 9, 7, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 9, 1'b0);
    chk("lk9_blocked_in_cmp", last_lr, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 9, 1'b0);
    chk("lk9_granted_k2", last_lr, 1'b1);
    idle_cycle();
    chk("lk9_value", last_lk, 7);

    pat_u = '0;
    pat_l = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, $urandom_range(0, 15), $urandom_range(0, 255),
            1'b1, $urandom_range(0, 15), 1'b0);
      pat_u = {pat_u[6:0], last_ur};
      pat_l = {pat_l[6:0], last_lr};
    end
    chk("arb_upd_pattern", pat_u, 8'h92);
    chk("arb_lk_pattern", pat_l, 8'h24);
    for (int i = 0; i < 3; i++) idle_cycle();

    cycle(1'b1, 200, 255, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    chk("clr_busy_rise", bus.busy, 1'b1);
    n = 0;
    while (bus.busy && n < 1000) begin
      idle_cycle();
      n++;
    end
    chk("clr_cmd_cycles", n, DEPTH + 1);
    sweep_zero("sweep_after_clear");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 199) == 0);
    end
    n = 0;
    while ((bus.busy || m_cmp || m_done_cnt > 0) && n < 1000) begin
      idle_cycle();
      n++;
    end
    for (int i = 0; i < 16; i++) do_lk(i);

    cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    n = 0;
    while (m_clear_left != DEPTH - 100 && n < 1000) begin
      idle_cycle();
      n++;
    end
    #1;
    chk("pre_rst_addr", bus.mem_addr_w, 100);
    reset_dut(1'b1);
    run_fill("fill_after_mid_reset", DEPTH);
    sweep_zero("sweep_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
